// File: rtl/rename_pkg.sv
// rename_pkg
//   Shared sizing constants and the retire-queue entry layout for the
//   rename/retire unit. Imported by rename_retire_unit and retire_map.
package rename_pkg;

  localparam int unsigned ARCH_REG_BITS = 5;   // 32 architectural registers
  localparam int unsigned PHYS_REG_BITS = 6;   // 64 physical registers
  localparam int unsigned ROB_DEPTH     = 16;  // retire queue entries, power of two
  localparam int unsigned TAG_BITS      = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic                     has_dest;
    logic [ARCH_REG_BITS-1:0] dest_arch;
    logic [PHYS_REG_BITS-1:0] new_phys;
    logic [PHYS_REG_BITS-1:0] old_phys;
    logic                     done;
    logic                     occupied;
  } retire_entry_t;

endpackage

// File: rtl/retire_map.sv
// retire_map
//   Committed (architectural) register map: arch reg -> phys reg.
//   Resets to the identity mapping. One synchronous write port, one
//   combinational read port. Arch reg 0 is hard-wired to phys reg 0.
// Ports:
//   clk, reset          clock, async active-high reset
//   wr_en/wr_arch/wr_phys  write port (applied on rising edge)
//   rd_arch/rd_phys     combinational read port
module retire_map
  import rename_pkg::*;
#(
  parameter int unsigned ARCH_REG_BITS = rename_pkg::ARCH_REG_BITS,
  parameter int unsigned PHYS_REG_BITS = rename_pkg::PHYS_REG_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ARCH_REG_BITS-1:0] wr_arch,
  input  logic [PHYS_REG_BITS-1:0] wr_phys,
  input  logic [ARCH_REG_BITS-1:0] rd_arch,
  output logic [PHYS_REG_BITS-1:0] rd_phys
);

  localparam int unsigned NUM_ARCH = 2 ** ARCH_REG_BITS;

  logic [PHYS_REG_BITS-1:0] map_q [NUM_ARCH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ARCH; i++) begin
        map_q[i] <= PHYS_REG_BITS'(i);
      end
    end else if (wr_en && (wr_arch != '0)) begin
      map_q[wr_arch] <= wr_phys;
    end
  end

  assign rd_phys = map_q[rd_arch];

endmodule

// File: rtl/rename_retire_unit.sv
// rename_retire_unit
//   In-order retire queue for renamed instructions. Rename allocates
//   entries at the tail, execution marks them done by tag in any order,
//   and the head retires one done entry per cycle, updating the committed
//   map and returning the previous physical mapping to the free list.
// Ports:
//   alloc_*     allocation handshake from rename (alloc_ready/alloc_tag out)
//   complete_*  completion report from execution
//   commit_*    registered pulse describing each retired mapping
//   free_*      registered pulse returning the old phys reg
//   rd_arch_reg/rd_committed_phys  committed-map read port
//   rob_count/rob_empty  occupancy status
module rename_retire_unit
  import rename_pkg::*;
#(
  parameter int unsigned ARCH_REG_BITS = rename_pkg::ARCH_REG_BITS,
  parameter int unsigned PHYS_REG_BITS = rename_pkg::PHYS_REG_BITS,
  parameter int unsigned ROB_DEPTH     = rename_pkg::ROB_DEPTH,
  localparam int unsigned TAG_BITS     = $clog2(ROB_DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_valid,
  input  logic                     alloc_has_dest,
  input  logic [ARCH_REG_BITS-1:0] alloc_dest_arch_reg,
  input  logic [PHYS_REG_BITS-1:0] alloc_new_phys_reg,
  input  logic [PHYS_REG_BITS-1:0] alloc_old_phys_reg,
  output logic                     alloc_ready,
  output logic [TAG_BITS-1:0]      alloc_tag,
  input  logic                     complete_valid,
  input  logic [TAG_BITS-1:0]      complete_tag,
  output logic                     commit_valid,
  output logic                     commit_has_dest,
  output logic [ARCH_REG_BITS-1:0] commit_arch_reg,
  output logic [PHYS_REG_BITS-1:0] commit_phys_reg,
  output logic                     free_valid,
  output logic [PHYS_REG_BITS-1:0] free_phys_reg,
  input  logic [ARCH_REG_BITS-1:0] rd_arch_reg,
  output logic [PHYS_REG_BITS-1:0] rd_committed_phys,
  output logic [TAG_BITS:0]        rob_count,
  output logic                     rob_empty
);

  retire_entry_t       rob_q [ROB_DEPTH];
  logic [TAG_BITS-1:0] head_q;
  logic [TAG_BITS-1:0] tail_q;
  logic [TAG_BITS:0]   count_q;

  retire_entry_t head_entry;
  logic          full;
  logic          do_alloc;
  logic          do_retire;
  logic          map_wr_en;

  always_comb begin
    head_entry = rob_q[head_q];
    full       = (count_q == (TAG_BITS+1)'(ROB_DEPTH));
    do_alloc   = alloc_valid && !full;
    do_retire  = head_entry.occupied && head_entry.done;
    map_wr_en  = do_retire && head_entry.has_dest;
  end

  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;
  assign rob_count   = count_q;
  assign rob_empty   = (count_q == '0);

  // Write order matters: completion, then retire clear, then allocation.
  // Alloc and retire never hit the same slot (that would need a full
  // queue), and a late completion on the retiring head is overridden by
  // the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_valid    <= 1'b0;
      commit_has_dest <= 1'b0;
      commit_arch_reg <= '0;
      commit_phys_reg <= '0;
      free_valid      <= 1'b0;
      free_phys_reg   <= '0;
    end else begin
      if (complete_valid && rob_q[complete_tag].occupied) begin
        rob_q[complete_tag].done <= 1'b1;
      end

      if (do_retire) begin
        rob_q[head_q] <= '0;
        head_q        <= head_q + 1'b1;
      end

      if (do_alloc) begin
        rob_q[tail_q] <= '{has_dest:  alloc_has_dest,
                           dest_arch: alloc_dest_arch_reg,
                           new_phys:  alloc_new_phys_reg,
                           old_phys:  alloc_old_phys_reg,
                           done:      1'b0,
                           occupied:  1'b1};
        tail_q        <= tail_q + 1'b1;
      end

      if (do_alloc && !do_retire) begin
        count_q <= count_q + 1'b1;
      end else if (do_retire && !do_alloc) begin
        count_q <= count_q - 1'b1;
      end

      commit_valid    <= do_retire;
      commit_has_dest <= map_wr_en;
      commit_arch_reg <= do_retire ? head_entry.dest_arch : '0;
      commit_phys_reg <= do_retire ? head_entry.new_phys  : '0;
      free_valid      <= map_wr_en;
      free_phys_reg   <= map_wr_en ? head_entry.old_phys  : '0;
    end
  end

  retire_map #(
    .ARCH_REG_BITS(ARCH_REG_BITS),
    .PHYS_REG_BITS(PHYS_REG_BITS)
  ) u_retire_map (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (map_wr_en),
    .wr_arch (head_entry.dest_arch),
    .wr_phys (head_entry.new_phys),
    .rd_arch (rd_arch_reg),
    .rd_phys (rd_committed_phys)
  );

endmodule

// File: tb/tb_rename_retire_unit.sv
// tb_rename_retire_unit
//   Directed self-checking bench for rename_retire_unit. Each scenario
//   task drives its stimulus and checks hand-computed expectations.
module tb_rename_retire_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_valid;
  logic       alloc_has_dest;
  logic [4:0] alloc_dest_arch_reg;
  logic [5:0] alloc_new_phys_reg;
  logic [5:0] alloc_old_phys_reg;
  logic       alloc_ready;
  logic [3:0] alloc_tag;
  logic       complete_valid;
  logic [3:0] complete_tag;
  logic       commit_valid;
  logic       commit_has_dest;
  logic [4:0] commit_arch_reg;
  logic [5:0] commit_phys_reg;
  logic       free_valid;
  logic [5:0] free_phys_reg;
  logic [4:0] rd_arch_reg;
  logic [5:0] rd_committed_phys;
  logic [4:0] rob_count;
  logic       rob_empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rename_retire_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .alloc_valid         (alloc_valid),
    .alloc_has_dest      (alloc_has_dest),
    .alloc_dest_arch_reg (alloc_dest_arch_reg),
    .alloc_new_phys_reg  (alloc_new_phys_reg),
    .alloc_old_phys_reg  (alloc_old_phys_reg),
    .alloc_ready         (alloc_ready),
    .alloc_tag           (alloc_tag),
    .complete_valid      (complete_valid),
    .complete_tag        (complete_tag),
    .commit_valid        (commit_valid),
    .commit_has_dest     (commit_has_dest),
    .commit_arch_reg     (commit_arch_reg),
    .commit_phys_reg     (commit_phys_reg),
    .free_valid          (free_valid),
    .free_phys_reg       (free_phys_reg),
    .rd_arch_reg         (rd_arch_reg),
    .rd_committed_phys   (rd_committed_phys),
    .rob_count           (rob_count),
    .rob_empty           (rob_empty)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset               = 1'b1;
    alloc_valid         = 1'b0;
    alloc_has_dest      = 1'b0;
    alloc_dest_arch_reg = '0;
    alloc_new_phys_reg  = '0;
    alloc_old_phys_reg  = '0;
    complete_valid      = 1'b0;
    complete_tag        = '0;
    rd_arch_reg         = '0;
    tick;
    tick;
    reset = 1'b0;
    #1;
  endtask

  task automatic alloc(input logic hd, input logic [4:0] d, input logic [5:0] nw, input logic [5:0] old);
    alloc_valid         = 1'b1;
    alloc_has_dest      = hd;
    alloc_dest_arch_reg = d;
    alloc_new_phys_reg  = nw;
    alloc_old_phys_reg  = old;
    tick;
    alloc_valid = 1'b0;
  endtask

  task automatic complete(input logic [3:0] t);
    complete_valid = 1'b1;
    complete_tag   = t;
    tick;
    complete_valid = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    tick;
    rd_arch_reg = 5'd5;
    #1;
    if (rob_empty !== 1'b1) begin $display("FAIL reset_empty: got %0b expected 1", rob_empty); n_err++; end n_cmp++;
    if (rob_count !== 5'd0) begin $display("FAIL reset_count: got %0d expected 0", rob_count); n_err++; end n_cmp++;
    if (alloc_ready !== 1'b1) begin $display("FAIL reset_ready: got %0b expected 1", alloc_ready); n_err++; end n_cmp++;
    if (alloc_tag !== 4'd0) begin $display("FAIL reset_tag: got %0d expected 0", alloc_tag); n_err++; end n_cmp++;
    if (rd_committed_phys !== 6'd5) begin $display("FAIL reset_map5: got %0d expected 5", rd_committed_phys); n_err++; end n_cmp++;
    if (commit_valid !== 1'b0 || free_valid !== 1'b0) begin
      $display("FAIL reset_pulses: got commit=%0b free=%0b expected 0/0", commit_valid, free_valid); n_err++;
    end n_cmp++;
  endtask

  task automatic test_in_order;
    apply_reset;
    if (alloc_tag !== 4'd0) begin $display("FAIL io_tag0: got %0d expected 0", alloc_tag); n_err++; end n_cmp++;
    alloc(1'b1, 5'd5, 6'd32, 6'd5);
    if (alloc_tag !== 4'd1) begin $display("FAIL io_tag1: got %0d expected 1", alloc_tag); n_err++; end n_cmp++;
    alloc(1'b1, 5'd5, 6'd33, 6'd32);
    if (alloc_tag !== 4'd2) begin $display("FAIL io_tag2: got %0d expected 2", alloc_tag); n_err++; end n_cmp++;
    alloc(1'b1, 5'd6, 6'd34, 6'd6);
    complete(4'd2);
    if (commit_valid !== 1'b0) begin $display("FAIL io_no_early_commit: got %0b expected 0", commit_valid); n_err++; end n_cmp++;
    complete(4'd0);
    if (commit_valid !== 1'b0) begin $display("FAIL io_latency: got %0b expected 0", commit_valid); n_err++; end n_cmp++;
    complete(4'd1);
    if ({commit_valid, commit_has_dest, commit_arch_reg, commit_phys_reg, free_valid, free_phys_reg} !== {1'b1, 1'b1, 5'd5, 6'd32, 1'b1, 6'd5}) begin
      $display("FAIL io_commit0: got v=%0b a=%0d p=%0d fv=%0b fp=%0d expected 1/5/32/1/5",
               commit_valid, commit_arch_reg, commit_phys_reg, free_valid, free_phys_reg); n_err++;
    end n_cmp++;
    tick;
    if ({commit_valid, commit_arch_reg, commit_phys_reg, free_valid, free_phys_reg} !== {1'b1, 5'd5, 6'd33, 1'b1, 6'd32}) begin
      $display("FAIL io_commit1: got v=%0b a=%0d p=%0d fv=%0b fp=%0d expected 1/5/33/1/32",
               commit_valid, commit_arch_reg, commit_phys_reg, free_valid, free_phys_reg); n_err++;
    end n_cmp++;
    tick;
    if ({commit_valid, commit_arch_reg, commit_phys_reg, free_valid, free_phys_reg} !== {1'b1, 5'd6, 6'd34, 1'b1, 6'd6}) begin
      $display("FAIL io_commit2: got v=%0b a=%0d p=%0d fv=%0b fp=%0d expected 1/6/34/1/6",
               commit_valid, commit_arch_reg, commit_phys_reg, free_valid, free_phys_reg); n_err++;
    end n_cmp++;
    tick;
    if (commit_valid !== 1'b0 || free_valid !== 1'b0) begin
      $display("FAIL io_idle: got commit=%0b free=%0b expected 0/0", commit_valid, free_valid); n_err++;
    end n_cmp++;
    if (rob_empty !== 1'b1) begin $display("FAIL io_empty: got %0b expected 1", rob_empty); n_err++; end n_cmp++;
    rd_arch_reg = 5'd5;
    #1;
    if (rd_committed_phys !== 6'd33) begin $display("FAIL io_map5: got %0d expected 33", rd_committed_phys); n_err++; end n_cmp++;
    rd_arch_reg = 5'd6;
    #1;
    if (rd_committed_phys !== 6'd34) begin $display("FAIL io_map6: got %0d expected 34", rd_committed_phys); n_err++; end n_cmp++;
  endtask

  task automatic test_full;
    apply_reset;
    for (int i = 0; i < 16; i++) begin
      alloc(1'b1, 5'(i + 1), 6'(32 + i), 6'(i + 1));
    end
    if (alloc_ready !== 1'b0) begin $display("FAIL full_ready: got %0b expected 0", alloc_ready); n_err++; end n_cmp++;
    if (rob_count !== 5'd16) begin $display("FAIL full_count: got %0d expected 16", rob_count); n_err++; end n_cmp++;
    if (alloc_tag !== 4'd0) begin $display("FAIL full_tail_wrap: got %0d expected 0", alloc_tag); n_err++; end n_cmp++;
    alloc(1'b1, 5'd20, 6'd60, 6'd20);
    if (rob_count !== 5'd16) begin $display("FAIL full_ignored: got %0d expected 16", rob_count); n_err++; end n_cmp++;
    complete(4'd0);
    tick;
    if ({commit_valid, commit_arch_reg, commit_phys_reg, free_phys_reg} !== {1'b1, 5'd1, 6'd32, 6'd1}) begin
      $display("FAIL full_retire0: got v=%0b a=%0d p=%0d fp=%0d expected 1/1/32/1",
               commit_valid, commit_arch_reg, commit_phys_reg, free_phys_reg); n_err++;
    end n_cmp++;
    if (rob_count !== 5'd15) begin $display("FAIL full_count15: got %0d expected 15", rob_count); n_err++; end n_cmp++;
    if (alloc_ready !== 1'b1) begin $display("FAIL full_ready_back: got %0b expected 1", alloc_ready); n_err++; end n_cmp++;
    if (alloc_tag !== 4'd0) begin $display("FAIL full_wrap_tag: got %0d expected 0", alloc_tag); n_err++; end n_cmp++;
    alloc(1'b1, 5'd21, 6'd61, 6'd21);
    if (rob_count !== 5'd16 || alloc_ready !== 1'b0) begin
      $display("FAIL full_refill: got count=%0d ready=%0b expected 16/0", rob_count, alloc_ready); n_err++;
    end n_cmp++;
    rd_arch_reg = 5'd1;
    #1;
    if (rd_committed_phys !== 6'd32) begin $display("FAIL full_map1: got %0d expected 32", rd_committed_phys); n_err++; end n_cmp++;
  endtask

  task automatic test_no_dest;
    apply_reset;
    alloc(1'b0, 5'd7, 6'd40, 6'd7);
    complete(4'd0);
    tick;
    if ({commit_valid, commit_has_dest, free_valid} !== 3'b100) begin
      $display("FAIL nd_pulse: got v=%0b hd=%0b fv=%0b expected 1/0/0", commit_valid, commit_has_dest, free_valid); n_err++;
    end n_cmp++;
    rd_arch_reg = 5'd7;
    #1;
    if (rd_committed_phys !== 6'd7) begin $display("FAIL nd_map7: got %0d expected 7", rd_committed_phys); n_err++; end n_cmp++;
    alloc(1'b1, 5'd0, 6'd41, 6'd0);
    complete(4'd1);
    tick;
    if ({commit_valid, free_valid, free_phys_reg} !== {1'b1, 1'b1, 6'd0}) begin
      $display("FAIL x0_pulse: got v=%0b fv=%0b fp=%0d expected 1/1/0", commit_valid, free_valid, free_phys_reg); n_err++;
    end n_cmp++;
    rd_arch_reg = 5'd0;
    #1;
    if (rd_committed_phys !== 6'd0) begin $display("FAIL x0_map: got %0d expected 0", rd_committed_phys); n_err++; end n_cmp++;
  endtask

  task automatic test_back_to_back;
    apply_reset;
    for (int i = 0; i < 8; i++) begin
      alloc(1'b1, 5'(8 + i), 6'(40 + i), 6'(8 + i));
    end
    complete(4'd0);
    if (rob_count !== 5'd8) begin $display("FAIL b2b_pre: got %0d expected 8", rob_count); n_err++; end n_cmp++;
    alloc(1'b1, 5'd16, 6'd48, 6'd16);
    if (rob_count !== 5'd8) begin $display("FAIL b2b_count: got %0d expected 8", rob_count); n_err++; end n_cmp++;
    if ({commit_valid, commit_phys_reg} !== {1'b1, 6'd40}) begin
      $display("FAIL b2b_commit: got v=%0b p=%0d expected 1/40", commit_valid, commit_phys_reg); n_err++;
    end n_cmp++;
    complete(4'd9);
    tick;
    if (rob_count !== 5'd8 || commit_valid !== 1'b0) begin
      $display("FAIL b2b_unocc: got count=%0d v=%0b expected 8/0", rob_count, commit_valid); n_err++;
    end n_cmp++;
    if (alloc_tag !== 4'd9) begin $display("FAIL b2b_tag9: got %0d expected 9", alloc_tag); n_err++; end n_cmp++;
    alloc(1'b1, 5'd17, 6'd49, 6'd17);
    for (int t = 1; t <= 8; t++) begin
      complete(4'(t));
    end
    tick;
    if ({commit_valid, commit_phys_reg} !== {1'b1, 6'd48}) begin
      $display("FAIL b2b_last: got v=%0b p=%0d expected 1/48", commit_valid, commit_phys_reg); n_err++;
    end n_cmp++;
    tick;
    tick;
    if (rob_count !== 5'd1 || commit_valid !== 1'b0) begin
      $display("FAIL b2b_tag9_pending: got count=%0d v=%0b expected 1/0", rob_count, commit_valid); n_err++;
    end n_cmp++;
  endtask

  task automatic test_reset_mid;
    apply_reset;
    alloc(1'b1, 5'd5, 6'd32, 6'd5);
    alloc(1'b1, 5'd6, 6'd33, 6'd6);
    alloc(1'b1, 5'd7, 6'd34, 6'd7);
    complete(4'd0);
    reset = 1'b1;
    #1;
    if (rob_count !== 5'd0 || rob_empty !== 1'b1) begin
      $display("FAIL rm_count: got count=%0d empty=%0b expected 0/1", rob_count, rob_empty); n_err++;
    end n_cmp++;
    tick;
    if (commit_valid !== 1'b0 || free_valid !== 1'b0) begin
      $display("FAIL rm_pulse_hold: got commit=%0b free=%0b expected 0/0", commit_valid, free_valid); n_err++;
    end n_cmp++;
    reset = 1'b0;
    tick;
    tick;
    if (commit_valid !== 1'b0 || free_valid !== 1'b0 || rob_count !== 5'd0) begin
      $display("FAIL rm_after: got commit=%0b free=%0b count=%0d expected 0/0/0", commit_valid, free_valid, rob_count); n_err++;
    end n_cmp++;
    rd_arch_reg = 5'd5;
    #1;
    if (rd_committed_phys !== 6'd5) begin $display("FAIL rm_map5: got %0d expected 5", rd_committed_phys); n_err++; end n_cmp++;
  endtask

  initial begin
    test_reset;
    test_in_order;
    test_full;
    test_no_dest;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
